fwd_hazard_tracker: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the pipelined CPU, sitting beside decode. Records each issued instruction's destination(s) in an internal shift pipeline of DEPTH stages (EX, MEM, WB, ...). Compares every decode-stage source register against that pipeline to produce per-source forwarding selects. Raises a stall when the youngest producer is a load whose data is not yet available.

---
 rtl/fwd_hazard_tracker_if.sv | 31 +++
 rtl/fwd_hazard_tracker.sv | 97 +++++++++
 tb/tb_fwd_hazard_tracker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_tracker_if.sv
// Decode-side bundle for fwd_hazard_tracker: decode drives the id_* fields and
// pipeline controls, and the tracker returns forwarding selects and the stall.
interface fwd_hazard_tracker_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2
);
    logic                       id_valid;
    logic [NUM_SRC*REG_W-1:0]   id_src;
    logic [NUM_SRC-1:0]         id_src_used;
    logic [REG_W-1:0]           id_dst;
    logic                       id_write_reg;
    logic                       id_write_r0;
    logic                       id_is_load;
    logic                       pipe_hold;
    logic                       flush;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       hazard_stall;

    modport master (
        output id_valid, id_src, id_src_used, id_dst, id_write_reg,
               id_write_r0, id_is_load, pipe_hold, flush,
        input  fwd_sel, hazard_stall
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dst, id_write_reg,
               id_write_r0, id_is_load, pipe_hold, flush,
        output fwd_sel, hazard_stall
    );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Operand-forwarding and load-use hazard unit beside decode.
// Define FWD_WRITE_R0_EN to track implicit R0 writes (id_write_r0).
module fwd_hazard_tracker #(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fwd_hazard_tracker_if.slave   bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        logic             write_reg;
`ifdef FWD_WRITE_R0_EN
        logic             write_r0;
`endif
        logic             is_load;
    } entry_t;

    // entry_q[1] is EX, entry_q[2] is MEM, and so on.
    entry_t                   entry_q [1:DEPTH];
    entry_t                   new_rec_d;
    logic [NUM_SRC-1:0]       src_haz_d;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_d;
    logic                     stall_d;

    function automatic logic entry_hit(entry_t e, logic [REG_W-1:0] src);
        logic hit;
        hit = e.write_reg && (e.dst == src);
`ifdef FWD_WRITE_R0_EN
        hit = hit || (e.write_r0 && (src == '0));
`endif
        return e.valid && hit;
    endfunction

`ifndef FWD_WRITE_R0_EN
    logic unused_write_r0;
    assign unused_write_r0 = bus.id_write_r0;
`endif

    // Scanning from the youngest stage, the first hit wins.
    always_comb begin
        // NOTE: every output of this block is defaulted up front so no path
        // leaves a value unassigned and no latch is inferred.
        fwd_sel_d = '0;
        src_haz_d = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            logic found;
            found = 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && bus.id_src_used[s] &&
                    entry_hit(entry_q[k], bus.id_src[s*REG_W +: REG_W])) begin
                    found = 1'b1;
                    if (entry_q[k].is_load && (k < LOAD_STAGE))
                        src_haz_d[s] = 1'b1;
                    else
                        fwd_sel_d[s*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    assign stall_d = bus.id_valid && (|src_haz_d);

    always_comb begin
        new_rec_d           = '0;
        new_rec_d.valid     = bus.id_valid && !stall_d && !bus.flush;
        new_rec_d.dst       = bus.id_dst;
        new_rec_d.write_reg = bus.id_write_reg;
`ifdef FWD_WRITE_R0_EN
        new_rec_d.write_r0  = bus.id_write_r0;
`endif
        new_rec_d.is_load   = bus.id_is_load;
    end

    // NOTE: the whole entry array is reset, not just a read pointer, because
    // a stale valid bit would produce false forwards right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) entry_q[k] <= '0;
        end else if (!bus.pipe_hold) begin
            // NOTE: non-blocking assignments let every stage shift from the
            // pre-edge values regardless of statement order.
            for (int k = DEPTH; k >= 2; k--) entry_q[k] <= entry_q[k-1];
            entry_q[1] <= new_rec_d;
        end
    end

    assign bus.fwd_sel      = fwd_sel_d;
    assign bus.hazard_stall = stall_d;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker (DEPTH=3, LOAD_STAGE=2); the R0
// expectation follows whether FWD_WRITE_R0_EN is defined for the build.
module tb_fwd_hazard_tracker;
    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int LOAD_ST = 2;
    localparam int SEL_W   = 2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fwd_hazard_tracker_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    fwd_hazard_tracker #(
        .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
        .LOAD_STAGE(LOAD_ST), .SEL_W(SEL_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input int s);
        return 32'(bus.fwd_sel[s*SEL_W +: SEL_W]);
    endfunction

    task automatic drive(input logic valid, input logic [4:0] src0, input logic [4:0] src1,
                         input logic [1:0] used, input logic [4:0] dst, input logic wr,
                         input logic wr0, input logic ld);
        bus.id_valid     = valid;
        bus.id_src       = {src1, src0};
        bus.id_src_used  = used;
        bus.id_dst       = dst;
        bus.id_write_reg = wr;
        bus.id_write_r0  = wr0;
        bus.id_is_load   = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.pipe_hold = 1'b0;
        bus.flush     = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("reset_fwd", 32'(bus.fwd_sel), 32'd0);
        check("reset_stall", 32'(bus.hazard_stall), 32'd0);
        tick();
        rst_n = 1'b1;

        // Back-to-back ALU dependence, then distance two.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 1'b0);
        check("alu_fwd0_ex", fwd(0), 32'd1);
        check("alu_stall", 32'(bus.hazard_stall), 32'd0);
        tick();
        drive(1'b1, 5'd5, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        check("alu_fwd0_mem", fwd(0), 32'd2);
        check("alu_fwd1_ex", fwd(1), 32'd1);
        tick();

        // Youngest producer wins; an unused source never matches.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd3, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
        check("young_fwd1", fwd(1), 32'd1);
        check("unused_fwd0", fwd(0), 32'd0);
        tick();

        // Load-use: one stall cycle, then forward from MEM.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        check("ld_stall", 32'(bus.hazard_stall), 32'd1);
        check("ld_fwd0_stall", fwd(0), 32'd0);
        drive(1'b0, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        check("ld_novalid_stall", 32'(bus.hazard_stall), 32'd0);
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ld_after_stall", 32'(bus.hazard_stall), 32'd0);
        check("ld_fwd0_mem", fwd(0), 32'd2);
        tick();

        // Implicit R0 write.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef FWD_WRITE_R0_EN
        check("r0_fwd0", fwd(0), 32'd1);
`else
        check("r0_fwd0", fwd(0), 32'd0);
`endif
        check("r0_stall", 32'(bus.hazard_stall), 32'd0);
        tick();

        // Hold freezes the pipe and ignores flush; flush then bubbles stage 1.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        bus.pipe_hold = 1'b1;
        bus.flush     = 1'b1;
        drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("hold_fwd0", fwd(0), 32'd1);
            tick();
        end
        check("hold_fwd0_end", fwd(0), 32'd1);
        bus.pipe_hold = 1'b0;
        tick();
        bus.flush = 1'b0;
        drive(1'b1, 5'd12, 5'd13, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        check("flush_fwd0", fwd(0), 32'd2);
        check("flush_fwd1", fwd(1), 32'd0);
        tick();

        // Stall and flush together leave a bubble in stage 1.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd21, 1'b1, 1'b0, 1'b1);
        tick();
        bus.flush = 1'b1;
        drive(1'b1, 5'd21, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sf_stall", 32'(bus.hazard_stall), 32'd1);
        tick();
        bus.flush = 1'b0;
        drive(1'b1, 5'd21, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        check("sf_fwd0", fwd(0), 32'd2);
        check("sf_stall_after", 32'(bus.hazard_stall), 32'd0);
        tick();

        // Hold keeps a stall alive; reset aborts it at once.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd20, 1'b1, 1'b0, 1'b1);
        tick();
        bus.pipe_hold = 1'b1;
        drive(1'b1, 5'd20, 5'd20, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        check("hs_stall", 32'(bus.hazard_stall), 32'd1);
        tick();
        check("hs_stall_held", 32'(bus.hazard_stall), 32'd1);
        check("hs_fwd_held", 32'(bus.fwd_sel), 32'd0);
        bus.pipe_hold = 1'b0;
        #1;
        check("hs_stall_release", 32'(bus.hazard_stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", 32'(bus.hazard_stall), 32'd0);
        check("rst_mid_fwd", 32'(bus.fwd_sel), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_fwd", 32'(bus.fwd_sel), 32'd0);
        check("post_rst_stall", 32'(bus.hazard_stall), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
